// File: rtl/cpu6502_pc_sequencer.sv
// ============================================================================
// Module  : cpu6502_pc_sequencer
// Purpose : Owns the 6502 program counter and sequences operand fetches for
//           relative branches, JMP abs, JMP (ind) and operand-skip increments
//           with NMOS-accurate cycle counts.
// Option  : CPU6502_IND_PAGEFIX_EN - when defined, the JMP (ind) high-byte
//           fetch carries into the pointer high byte (65C02 behaviour);
//           otherwise it wraps within the pointer page (NMOS behaviour).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu6502_pc_sequencer #(
   parameter logic [15:0] RESET_PC = 16'hFFFC
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        start,
   input  logic [1:0]  opType,
   input  logic        branchTaken,
   input  logic        pcLoad,
   input  logic [15:0] pcLoadValue,
   input  logic [7:0]  memData,
   input  logic        memReady,
   output logic [15:0] memAddr,
   output logic        memRead,
   output logic [15:0] pc,
   output logic        busy,
   output logic        done,
   output logic        pageCross
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_OP1    = 3'd1,
      S_OP2    = 3'd2,
      S_BR_ADD = 3'd3,
      S_BR_FIX = 3'd4,
      S_IND_LO = 3'd5,
      S_IND_HI = 3'd6
   } state_t;

   localparam logic [1:0] OP_BRANCH  = 2'b00;
   localparam logic [1:0] OP_JMP_ABS = 2'b01;
   localparam logic [1:0] OP_INC     = 2'b11;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  hi_q, hi_d;    // operand high byte, or branch target page in BR_FIX
   logic [7:0]  tmp_q, tmp_d;  // low byte of the indirect target
   logic [1:0]  op_q, op_d;    // operation captured at start
   logic        page_cross_q, page_cross_d;

   logic [15:0] br_sum;
   logic [15:0] ind_hi_addr;

   // Full 16-bit signed sum; only its high byte decides whether a fix-up cycle is needed.
   assign br_sum = pc_q + {{8{lo_q[7]}}, lo_q};

`ifdef CPU6502_IND_PAGEFIX_EN
   assign ind_hi_addr = {hi_q, lo_q} + 16'd1;
`else
   assign ind_hi_addr = {hi_q, lo_q + 8'd1};
`endif

   assign pc        = pc_q;
   assign busy      = (state_q != S_IDLE);
   assign pageCross = page_cross_q;

   // Next-state, datapath updates and bus/done outputs; pcLoad overrides everything.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      lo_d         = lo_q;
      hi_d         = hi_q;
      tmp_d        = tmp_q;
      op_d         = op_q;
      page_cross_d = page_cross_q;
      memRead      = 1'b0;
      memAddr      = 16'h0000;
      done         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (opType == OP_INC) begin
                  pc_d = pc_q + 16'd1;
                  done = 1'b1;
               end else begin
                  op_d         = opType;
                  page_cross_d = 1'b0;
                  state_d      = S_OP1;
               end
            end
         end
         S_OP1: begin
            memRead = 1'b1;
            memAddr = pc_q;
            if (memReady) begin
               lo_d = memData;
               pc_d = pc_q + 16'd1;
               if (op_q == OP_BRANCH) begin
                  if (branchTaken) begin
                     state_d = S_BR_ADD;
                  end else begin
                     done    = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  state_d = S_OP2;
               end
            end
         end
         S_OP2: begin
            memRead = 1'b1;
            memAddr = pc_q;
            if (memReady) begin
               hi_d = memData;
               if (op_q == OP_JMP_ABS) begin
                  pc_d    = {memData, lo_q};
                  done    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_IND_LO;
               end
            end
         end
         S_BR_ADD: begin
            pc_d = {pc_q[15:8], br_sum[7:0]};
            if (br_sum[15:8] == pc_q[15:8]) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               page_cross_d = 1'b1;
               hi_d         = br_sum[15:8];
               state_d      = S_BR_FIX;
            end
         end
         S_BR_FIX: begin
            pc_d    = {hi_q, pc_q[7:0]};
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_IND_LO: begin
            memRead = 1'b1;
            memAddr = {hi_q, lo_q};
            if (memReady) begin
               tmp_d   = memData;
               state_d = S_IND_HI;
            end
         end
         S_IND_HI: begin
            memRead = 1'b1;
            memAddr = ind_hi_addr;
            if (memReady) begin
               pc_d    = {memData, tmp_q};
               done    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // An external load aborts whatever was in flight and discards its side effects.
      if (pcLoad) begin
         pc_d         = pcLoadValue;
         state_d      = S_IDLE;
         done         = 1'b0;
         lo_d         = lo_q;
         hi_d         = hi_q;
         tmp_d        = tmp_q;
         op_d         = op_q;
         page_cross_d = page_cross_q;
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         lo_q         <= 8'h00;
         hi_q         <= 8'h00;
         tmp_q        <= 8'h00;
         op_q         <= 2'b00;
         page_cross_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         lo_q         <= lo_d;
         hi_q         <= hi_d;
         tmp_q        <= tmp_d;
         op_q         <= op_d;
         page_cross_q <= page_cross_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cpu6502_pc_sequencer.sv
// ============================================================================
// Module  : tb_cpu6502_pc_sequencer
// Purpose : Self-checking bench for cpu6502_pc_sequencer. A transaction-level
//           model predicts read addresses, final PC, cycle count and page
//           cross for each operation; a random-latency memory answers reads.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cpu6502_pc_sequencer;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  opType = 2'b00;
   logic        branchTaken = 1'b0;
   logic        pcLoad = 1'b0;
   logic [15:0] pcLoadValue = 16'h0000;
   logic [7:0]  memData = 8'h00;
   logic        memReady = 1'b0;
   logic [15:0] memAddr;
   logic        memRead;
   logic [15:0] pc;
   logic        busy;
   logic        done;
   logic        pageCross;

   int total = 0;
   int bad   = 0;

   logic [7:0]  mem [0:65535];
   logic [15:0] m_pc;
   logic        m_cross;

   cpu6502_pc_sequencer #(.RESET_PC(16'hFFFC)) dut (
      .clk        (clk),
      .resetN     (resetN),
      .start      (start),
      .opType     (opType),
      .branchTaken(branchTaken),
      .pcLoad     (pcLoad),
      .pcLoadValue(pcLoadValue),
      .memData    (memData),
      .memReady   (memReady),
      .memAddr    (memAddr),
      .memRead    (memRead),
      .pc         (pc),
      .busy       (busy),
      .done       (done),
      .pageCross  (pageCross)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load_pc(input logic [15:0] v);
      @(posedge clk); #1;
      start = 1'b0; memReady = 1'b0; pcLoad = 1'b1; pcLoadValue = v;
      @(posedge clk); #1;
      pcLoad = 1'b0;
      m_pc = v;
      @(negedge clk);
      check("pc_load", pc, v);
   endtask

   // One operation from the current model PC. force_stall cycles of
   // memReady=0 are inserted at the second read, then stall_pct applies.
   task automatic run_op(input logic [1:0] op, input logic tk, input int stall_pct,
                         input int force_stall);
      logic [15:0] a0, a1, ptr, ptr2, tgt, ex_pc, mid_pc;
      logic [15:0] addrs [4];
      logic        ex_cross, got_done;
      int          nreads, ex_cyc, soff, ridx, k, forced;
      a0 = m_pc;
      a1 = m_pc + 16'd1;
      nreads = 0; ex_cyc = 0; ex_cross = 1'b0; ex_pc = a1; mid_pc = a1; tgt = a1;
      for (int i = 0; i < 4; i++) addrs[i] = 16'h0000;
      case (op)
         2'b00: begin
            nreads = 1; addrs[0] = a0;
            soff = int'(mem[a0]);
            if (soff >= 128) soff = soff - 256;
            tgt = 16'(int'(a1) + soff);
            if (!tk) begin
               ex_pc = a1; ex_cyc = 1;
            end else begin
               ex_pc = tgt;
               ex_cross = ((tgt >> 8) != (a1 >> 8));
               ex_cyc = ex_cross ? 3 : 2;
               mid_pc = (a1 & 16'hFF00) | (tgt & 16'h00FF);
            end
         end
         2'b01: begin
            nreads = 2; addrs[0] = a0; addrs[1] = a1;
            ex_pc = {mem[a1], mem[a0]}; ex_cyc = 2;
         end
         2'b10: begin
            ptr = {mem[a1], mem[a0]};
`ifdef CPU6502_IND_PAGEFIX_EN
            ptr2 = ptr + 16'd1;
`else
            ptr2 = (ptr & 16'hFF00) | ((ptr + 16'd1) & 16'h00FF);
`endif
            nreads = 4; addrs[0] = a0; addrs[1] = a1; addrs[2] = ptr; addrs[3] = ptr2;
            ex_pc = {mem[ptr2], mem[ptr]}; ex_cyc = 4;
         end
         default: begin
            ex_pc = a1; ex_cyc = 0; ex_cross = m_cross;
         end
      endcase

      @(posedge clk); #1;
      start = 1'b1; opType = op; pcLoad = 1'b0;
      branchTaken = 1'($urandom); memReady = 1'($urandom); memData = 8'($urandom);
      @(negedge clk);
      check("start_done", done, (op == 2'b11));

      ridx = 0; k = 0; got_done = 1'b0; forced = force_stall;
      if (op != 2'b11) begin
         for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
            @(posedge clk); #1;
            start = 1'($urandom); opType = 2'($urandom); branchTaken = 1'($urandom);
            if (memRead) begin
               check("read_idx", (ridx < nreads), 1);
               check("mem_addr", memAddr, addrs[ridx & 3]);
               check("pc_during_read", pc, (ridx == 0) ? a0 : a1);
               if (ridx == 1 && forced > 0) begin
                  memReady = 1'b0; forced--;
               end else begin
                  memReady = ($urandom_range(0, 99) >= stall_pct);
               end
               memData = memReady ? mem[memAddr] : 8'($urandom);
               if (memReady) begin
                  ridx++; k++;
                  if (op == 2'b00) branchTaken = tk;
               end
            end else begin
               memReady = 1'($urandom); memData = 8'($urandom); k++;
               if (op == 2'b00 && ex_cross && k == 3) check("br_mid_pc", pc, mid_pc);
            end
            @(negedge clk);
            check("busy_in_op", busy, 1);
            if (done) begin
               got_done = 1'b1;
               check("cycles", k, ex_cyc);
            end
         end
         check("done_seen", got_done, 1);
      end

      @(posedge clk); #1;
      start = 1'b0; memReady = 1'b0;
      @(negedge clk);
      check("final_pc", pc, ex_pc);
      check("final_busy", busy, 0);
      check("final_read", memRead, 0);
      check("page_cross", pageCross, ex_cross);
      check("done_low", done, 0);
      m_pc = ex_pc;
      m_cross = ex_cross;
   endtask

   // Start JMP (ind), let both operand reads complete, then pcLoad in IND_LO.
   task automatic run_abort(input logic [15:0] newpc);
      logic [15:0] a0, a1;
      a0 = m_pc; a1 = m_pc + 16'd1;
      @(posedge clk); #1;
      start = 1'b1; opType = 2'b10;
      @(posedge clk); #1;
      start = 1'b0; memReady = 1'b1; memData = mem[a0];
      @(posedge clk); #1;
      memData = mem[a1];
      @(posedge clk); #1;
      check("abort_in_ind_lo", memAddr, {mem[a1], mem[a0]});
      pcLoad = 1'b1; pcLoadValue = newpc; memReady = 1'b1; memData = 8'h5A;
      @(negedge clk);
      check("abort_no_done", done, 0);
      @(posedge clk); #1;
      pcLoad = 1'b0; memReady = 1'b0;
      @(negedge clk);
      check("abort_pc", pc, newpc);
      check("abort_busy", busy, 0);
      check("abort_read", memRead, 0);
      check("abort_done", done, 0);
      m_pc = newpc;
      m_cross = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      m_pc = 16'hFFFC;
      m_cross = 1'b0;

      // Reset state, checked while reset is still asserted and after release.
      #12;
      check("rst_pc", pc, 16'hFFFC);
      check("rst_busy", busy, 0);
      check("rst_read", memRead, 0);
      check("rst_addr", memAddr, 0);
      check("rst_done", done, 0);
      check("rst_pcross", pageCross, 0);
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      check("post_rst_pc", pc, 16'hFFFC);
      check("post_rst_busy", busy, 0);

      load_pc(16'h8000);

      // Branch taken, same page.
      load_pc(16'h8010); mem[16'h8010] = 8'h05;
      run_op(2'b00, 1'b1, 0, 0);
      check("tp_br_same", pc, 16'h8016);

      // Branch taken, crossing upward then downward.
      load_pc(16'h80F0); mem[16'h80F0] = 8'h20;
      run_op(2'b00, 1'b1, 0, 0);
      check("tp_br_up", pc, 16'h8111);
      load_pc(16'h8002); mem[16'h8002] = 8'hFA;
      run_op(2'b00, 1'b1, 0, 0);
      check("tp_br_down", pc, 16'h7FFD);

      // Extreme offsets.
      load_pc(16'h8040); mem[16'h8040] = 8'h80;
      run_op(2'b00, 1'b1, 0, 0);
      check("tp_br_m128", pc, 16'h7FC1);
      load_pc(16'h8040); mem[16'h8040] = 8'h7F;
      run_op(2'b00, 1'b1, 0, 0);
      check("tp_br_p127", pc, 16'h80C0);

      // Branch not taken.
      load_pc(16'h8010); mem[16'h8010] = 8'h40;
      run_op(2'b00, 1'b0, 0, 0);
      check("tp_br_nt", pc, 16'h8011);

      // JMP (ind) with the pointer on a page boundary.
      load_pc(16'h0200);
      mem[16'h0200] = 8'hFF; mem[16'h0201] = 8'h30;
      mem[16'h30FF] = 8'h80; mem[16'h3000] = 8'h50; mem[16'h3100] = 8'h40;
      run_op(2'b10, 1'b0, 0, 0);
`ifdef CPU6502_IND_PAGEFIX_EN
      check("tp_jmp_ind", pc, 16'h4080);
`else
      check("tp_jmp_ind", pc, 16'h5080);
`endif

      // JMP abs with a 3-cycle stall on the high-byte read.
      load_pc(16'h1234);
      run_op(2'b01, 1'b0, 0, 3);

      // Increment wrapping at the top of memory.
      load_pc(16'hFFFF);
      run_op(2'b11, 1'b0, 0, 0);
      check("tp_inc_wrap", pc, 16'h0000);

      // Abort of an indirect jump.
      load_pc(16'h0400);
      run_abort(16'hC000);

      // pcLoad wins over a same-cycle start.
      @(posedge clk); #1;
      start = 1'b1; opType = 2'b11; pcLoad = 1'b1; pcLoadValue = 16'hABCD;
      @(negedge clk);
      check("ld_vs_start_done", done, 0);
      @(posedge clk); #1;
      start = 1'b0; pcLoad = 1'b0;
      @(negedge clk);
      check("ld_vs_start_pc", pc, 16'hABCD);
      check("ld_vs_start_busy", busy, 0);
      m_pc = 16'hABCD;

      // Random operations with random bus latency, often near page edges.
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0)
               load_pc({8'($urandom), 8'($urandom_range(240, 255))});
            else
               load_pc(16'($urandom));
         end
         run_op(2'($urandom), 1'($urandom), 30, int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cpu6502_pc_sequencer.md
Name: cpu6502_pc_sequencer

Overview:
- Multi-cycle controller that owns the 6502 program counter register.
- Sequences operand fetches and PC updates for relative branches, JMP absolute, JMP indirect and plain operand-skip increments.
- Reproduces NMOS cycle counts:
  - branch: 2 cycles not taken, 3 taken same page, 4 taken cross page.
  - JMP abs: 2 cycles after the opcode; JMP ind: 4 cycles after the opcode.
- Sits between the instruction decoder (issues start/opType) and the memory bus interface (read handshake).

Parameters:
RESET_PC, 16'hFFFC, PC value loaded on asynchronous reset.

Ports:
clk  input  1  system clock, rising edge.
resetN  input  1  asynchronous active-low reset.
start  input  1  one-cycle request from decoder; sampled only in IDLE.
opType  input  2  00 branch, 01 JMP abs, 10 JMP ind, 11 increment (skip one operand byte).
branchTaken  input  1  branch condition; sampled in the cycle the offset byte is accepted.
pcLoad  input  1  synchronous PC overwrite (vectors, RTS/RTI); highest priority.
pcLoadValue  input  16  value for pcLoad.
memData  input  8  read data from bus, valid when memReady=1.
memReady  input  1  completes the current read this cycle.
memAddr  output  16  read address.
memRead  output  1  read request; held with memAddr stable until memReady.
pc  output  16  current program counter.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse on the final cycle of an operation.
pageCross  output  1  registered; set when a taken branch crossed a page; cleared on next start.

Behaviour:
- Reset (resetN=0, async):
  - pc=RESET_PC, state=IDLE.
  - memRead=0, memAddr=0, done=0, pageCross=0, internal operand latches=0.
- States: IDLE, OP1, OP2, BR_ADD, BR_FIX, IND_LO, IND_HI.
- Bus rule: any state with memRead=1 stalls (all registers hold) while memReady=0; it advances on the cycle memReady=1.
- IDLE: memRead=0. On start:
  - opType 11 -> pc<=pc+1 (16-bit, wraps FFFF->0000), done=1 same cycle, stay IDLE.
  - otherwise -> OP1, pageCross<=0.
- OP1:
  - Read at pc; on accept: lo<=memData, pc<=pc+1.
  - Branch: not taken -> done, IDLE; taken -> BR_ADD.
  - JMP -> OP2.
- OP2:
  - Read at pc; on accept: hi<=memData.
  - JMP abs -> pc<={memData,lo}, done, IDLE.
  - JMP ind -> IND_LO.
- BR_ADD:
  - No bus read (memRead=0).
  - sum = pc + signext(lo), computed to 16 bits.
  - pc[7:0]<=sum[7:0]; pc[15:8] unchanged.
  - If sum[15:8]==pc[15:8] -> done, IDLE.
  - Else pageCross<=1, latch sum[15:8] -> BR_FIX.
- BR_FIX: pc[15:8]<=latched high byte, done, IDLE. This is 4 cycles total counting the opcode.
- IND_LO: read at {hi,lo}; on accept: tmp<=memData -> IND_HI.
- IND_HI:
  - Read at {hi, lo+1}, where lo+1 is 8-bit and wraps within the page (NMOS behaviour).
  - On accept: pc<={memData,tmp}, done, IDLE.
- Offset arithmetic:
  - Offset 80h = -128, 7Fh = +127, relative to the address after the offset byte.
  - Page crossing is judged on the true high byte of the signed sum, not on the raw 8-bit carry.
- Simultaneous events:
  - pcLoad: pc<=pcLoadValue, state<=IDLE, memRead<=0, done=0. Aborts any operation, wins over start, and wins over a same-cycle memReady.
  - start while busy is ignored.
- done asserts for exactly one cycle per accepted start, including opType 11. It never asserts on an aborted operation.
- memAddr is 0 whenever memRead=0.

Optional Feature:
- Macro: CPU6502_IND_PAGEFIX_EN.
- Defined: IND_HI reads {hi,lo}+1 with full 16-bit carry (65C02 fix). Cycle count is unchanged.
- Undefined: 8-bit wrap within the page as specified above. This is the default NMOS bug.

Test Plan:
- Reset then release: pc=FFFC, busy=0. Then pcLoad=1, pcLoadValue=8000 -> pc=8000.
- Branch taken, same page: pc=8010, offset 05, memReady=1 -> pc=8016. Total 2 cycles after start, done on 2nd, pageCross=0.
- Branch taken, crossing up and down:
  - pc=80F0, offset 20 -> pc reads 8011 after BR_ADD, then 8111 after BR_FIX, pageCross=1.
  - pc=8002, offset FA (-6) -> pc=7FFD, pageCross=1.
- Branch not taken: pc=8010, offset 40 -> pc=8011, done after 1 accepted read.
- JMP ind at page boundary:
  - Pointer 30FF, memory 30FF=80, 3000=50, 3100=40.
  - Macro undefined -> pc=5080; macro defined -> pc=4080.
- Stalls and abort:
  - memReady held 0 for 3 cycles during JMP abs OP2 -> memAddr/pc stable, busy=1, no done.
  - pcLoad during IND_LO -> pc=pcLoadValue, IDLE next cycle, no done pulse.
